minimal_mem_initiator: RTL

- Single-channel bus initiator (master) for the Bambu minimal memory interface: drives oe/we/addr/wdata/data_size, waits for DataRdy, returns read data.
- Lets benches and wrapper logic preload and read back accelerator-visible memory through a slave port (S_oe_ram/S_we_ram/...) or an off-chip memory model.
- Front side is a valid/ready command channel and a valid/ready response channel; one transaction outstanding at a time.

---
 rtl/minimal_mem_initiator.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/minimal_mem_initiator.sv
// Purpose : single-outstanding bus initiator for the Bambu minimal memory interface.
// Latency : bus asserted 1 cycle after command accept; response 1 cycle after DataRdy.
// Backpr. : cmd_ready only in IDLE; a response is held until rsp_ready, bus idle meanwhile.
//
// Ports: clock/reset (sync, active-high); cmd_* valid/ready command channel;
//        rsp_* valid/ready response channel; Mout_*/M_* memory bus; proto_err flag.
// Build option: define PROTOCOL_CHECK_EN to enable the sticky proto_err checker,
//               otherwise proto_err is tied low.
module minimal_mem_initiator #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SIZE_W-1:0] cmd_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [SIZE_W-1:0] Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy,
    output logic              proto_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SIZE_W:0] MAX_SIZE = (SIZE_W+1)'(DATA_W);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t            state_q, state_d;
    logic              oe_q, oe_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept, size_ok, done, timeout_hit, abort;

    // Low 'sz' bits set: equivalent to (1<<sz)-1 without needing a wider temporary.
    function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(sz));
        return m;
    endfunction

    assign accept  = cmd_valid && (state_q == IDLE);
    assign size_ok = (cmd_size != '0) && ({1'b0, cmd_size} <= MAX_SIZE);
    assign done    = (state_q == REQ) && M_DataRdy;

    // Counter holds the number of REQ cycles already spent without DataRdy.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign abort = (state_q == REQ) && !M_DataRdy && timeout_hit;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = size_ok ? REQ : RSP;
            REQ:     if (done || abort) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: handshakes plus next values of the registered bus/response.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        rsp_valid = (state_q == RSP);
        oe_d    = oe_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    rdata_d = '0;
                    err_d   = !size_ok;
                    if (size_ok) begin
                        oe_d    = !cmd_we;
                        we_d    = cmd_we;
                        addr_d  = cmd_addr;
                        wdata_d = cmd_we ? (cmd_wdata & size_mask(cmd_size)) : '0;
                        size_d  = cmd_size;
                    end
                end
            end
            REQ: begin
                if (done || abort) begin
                    // Shared buses are ORed in Bambu, so every field returns to zero.
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    size_d  = '0;
                    err_d   = abort;
                    rdata_d = (done && oe_q) ? (M_Rdata_ram & size_mask(size_q)) : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            oe_q    <= oe_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Mout_oe_ram        = oe_q;
    assign Mout_we_ram        = we_q;
    assign Mout_addr_ram      = addr_q;
    assign Mout_Wdata_ram     = wdata_q;
    assign Mout_data_ram_size = size_q;
    assign rsp_rdata          = rdata_q;
    assign rsp_err            = err_q;

`ifdef PROTOCOL_CHECK_EN
    logic proto_q;
    logic rdata_xz;
`ifdef SYNTHESIS
    assign rdata_xz = 1'b0;
`else
    assign rdata_xz = $isunknown(M_Rdata_ram);
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            proto_q <= 1'b0;
        end else if ((M_DataRdy && state_q != REQ) || (done && oe_q && rdata_xz) || abort) begin
            proto_q <= 1'b1;
        end
    end
    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
